divk_seq: RTL
=============

DIVK_SEQ -- requirements
Module: divk_seq

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits, legal range 8..64.
REQ-002 Parameter K, default 8: divisor D = 2^K - 1 (default D = 255), legal range 2..WIDTH-2.
REQ-003 Parameter SIGNED, default 1: 1 = two's-complement operand and results, 0 = unsigned.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  x is valid this cycle.
REQ-007 in_ready  output  1  block accepts an operand this cycle.
REQ-008 x  input  WIDTH  dividend.
REQ-009 out_valid  output  1  q and r are valid.
REQ-010 out_ready  input  1  consumer accepts the result this cycle.
REQ-011 q  output  WIDTH  quotient x / D.
REQ-012 r  output  WIDTH  remainder x % D.

Function
REQ-013 Handshake: input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
REQ-014 FSM states: IDLE, FOLD, FIX, HOLD.
REQ-015 in_ready SHALL be 1 only in IDLE; at most one operation in flight.
REQ-016 IDLE: on input transfer, register sign = SIGNED && x[WIDTH-1], m = |x| as a WIDTH-bit unsigned value, acc = 0, then go to FOLD.
REQ-017 FOLD: while m >= 2^K, set acc += m >> K and m = (m >> K) + (m & D), one step per cycle; when m < 2^K, go to FIX.
REQ-018 FIX: if m == D, set acc += 1 and m = 0; then apply sign (q = sign ? -acc : acc; r = sign ? -m : m), set out_valid, and go to HOLD.
REQ-019 Results SHALL truncate toward zero; r SHALL take the sign of x; results SHALL be exactly equal to Verilog signed (or unsigned) / and % by D.
REQ-020 SIGNED=1 with x = most-negative value SHALL divide correctly: the magnitude is unsigned WIDTH-bit, with no overflow.
REQ-021 Latency from input transfer to out_valid SHALL be at most WIDTH+3 cycles and at least 2 cycles (x < 2^K: FOLD exits immediately).
REQ-022 HOLD: q, r and out_valid SHALL stay stable until an output transfer; on transfer, drop out_valid and return to IDLE in the same edge.
REQ-023 in_valid asserted outside IDLE SHALL be ignored with no side effects.
REQ-024 Zero dividend SHALL produce q = 0, r = 0.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, out_valid 0, q 0, r 0, and internal acc/m/sign 0; in_ready SHALL read 1 during and after reset.
REQ-026 Reset asserted mid-FOLD, mid-FIX or in HOLD SHALL abandon the operation; no result SHALL be emitted after release.

Structure
REQ-027 A shared package divk_pkg SHALL hold the FSM state enum and a MAX_LAT(WIDTH) = WIDTH+3 constant function.
REQ-028 One sub-module, divk_fold, SHALL implement the combinational fold step: inputs m; outputs m_next, acc_inc, done (m < 2^K).

Verification
REQ-029 WIDTH=32, K=8: x = 255000 -> q = 1000, r = 0; x = 2550 -> q = 10, r = 0.
REQ-030 x = 255 -> q = 1, r = 0; x = 254 -> q = 0, r = 254, out_valid exactly 2 cycles after accept; x = 1020 -> q = 4, r = 0.
REQ-031 SIGNED=1: x = -1020 -> q = -4, r = 0; x = -1021 -> q = -4, r = -1; WIDTH=16, K=4: x = -32768 -> q = -2184, r = -8.
REQ-032 Backpressure: hold out_ready = 0 for 10 cycles in HOLD -> q, r and out_valid remain stable, in_ready = 0, and a new in_valid is ignored; with out_ready = 1, in_ready returns the next cycle.
REQ-033 Drop rst_n 3 cycles after accepting x = 255000 -> out_valid stays 0 and in_ready = 1; next operand x = 510 -> q = 2, r = 0.
REQ-034 Random regression of 10k operands per configuration (K in {2,4,8}, SIGNED in {0,1}) against a / and % reference model; every latency <= MAX_LAT.

Source files
------------

// File: rtl/divk_pkg.sv
// Shared types and constants for the divide-by-(2^K - 1) sequencer.
// Holds the FSM state encoding and the worst-case latency helper.
package divk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FOLD = 2'd1,
        FIX  = 2'd2,
        HOLD = 2'd3
    } state_t;

    // Cycles from input transfer to out_valid, upper bound.
    function automatic int MAX_LAT(input int width);
        return width + 3;
    endfunction

endpackage

// File: rtl/divk_fold.sv
// One combinational folding step for division by D = 2^K - 1.
// Since 2^K == 1 (mod D), hi*2^K + lo folds to hi + lo and hi joins the quotient.
module divk_fold
    import divk_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int K     = 8
) (
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] m_next,
    output logic [WIDTH-1:0] acc_inc,
    output logic             done
);

    localparam logic [WIDTH-1:0] D = {{(WIDTH-K){1'b0}}, {K{1'b1}}};

    assign acc_inc = m >> K;
    assign m_next  = acc_inc + (m & D);
    assign done    = (acc_inc == '0);

endmodule

// File: rtl/divk_seq.sv
// Sequential divider by D = 2^K - 1 using repeated digit folding.
// Works on the magnitude, then restores the sign so results truncate toward zero.
module divk_seq
    import divk_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int K      = 8,
    parameter int SIGNED = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output state_t           dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready are
    // both high; out_valid/q/r hold steady until out_ready is seen.

    localparam logic [WIDTH-1:0] D = {{(WIDTH-K){1'b0}}, {K{1'b1}}};

    state_t           state;
    logic             sign;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] acc;

    logic [WIDTH-1:0] m_next;
    logic [WIDTH-1:0] acc_inc;
    logic             done;

    logic             neg;
    logic             is_d;
    logic [WIDTH-1:0] acc_fix;
    logic [WIDTH-1:0] m_fix;

    divk_fold #(
        .WIDTH (WIDTH),
        .K     (K)
    ) u_fold (
        .m       (m),
        .m_next  (m_next),
        .acc_inc (acc_inc),
        .done    (done)
    );

    assign neg       = (SIGNED != 0) && x[WIDTH-1];
    assign in_ready  = (state == IDLE);
    assign dbg_state = state;

    // After folding, m lies in 0..D; D itself is one more multiple of D.
    assign is_d    = (m == D);
    assign acc_fix = acc + {{(WIDTH-1){1'b0}}, is_d};
    assign m_fix   = is_d ? '0 : m;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sign      <= 1'b0;
            m         <= '0;
            acc       <= '0;
            q         <= '0;
            r         <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign  <= neg;
                        // Negating the most-negative value yields 2^(WIDTH-1) unsigned.
                        m     <= neg ? -x : x;
                        acc   <= '0;
                        state <= FOLD;
                    end
                end
                FOLD: begin
                    if (done) begin
                        state <= FIX;
                    end else begin
                        acc <= acc + acc_inc;
                        m   <= m_next;
                    end
                end
                FIX: begin
                    acc       <= acc_fix;
                    m         <= m_fix;
                    q         <= sign ? -acc_fix : acc_fix;
                    r         <= sign ? -m_fix : m_fix;
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
